bpsk_rx: RTL and testbench
==========================

// Module: bpsk_rx
// PURPOSE
//  Coherent BPSK demodulator and frame synchroniser; receive-side counterpart of the BPSK transmitter.
//  Per sample, multiplies the received sample by a local carrier supplied by a shared phase-accumulator/CORDIC NCO.
//  Integrates and dumps over SAMPLES_PER_BIT samples and hard-decides each bit.
//  Hunts for an 8-bit preamble, resolves the 180-degree phase ambiguity, then outputs FRAME_BITS data bits.
// PARAMETERS
//  DATA_W          16        width of signed sample and carrier
//  SAMPLES_PER_BIT 16        valid samples integrated per bit (>=2)
//  ACC_W           40        accumulator width; must be >= 2*DATA_W + clog2(SAMPLES_PER_BIT)
//  PREAMBLE        8'hA5     sync word, sent MSB first
//  FRAME_BITS      64        data bits output per frame after preamble
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       asynchronous, active-low reset (0 = reset)
//  sample_in     in   DATA_W  signed received sample
//  carrier       in   DATA_W  signed local carrier, time-aligned with sample_in
//  sample_valid  in   1       sample_in/carrier valid this cycle
//  resync        in   1       synchronous: abandon frame, return to HUNT
//  bit_out       out  1       demodulated data bit (phase-corrected)
//  bit_valid     out  1       one-cycle strobe qualifying bit_out
//  locked        out  1       high while in LOCKED
//  inverted      out  1       1 = preamble received complemented; data is being inverted
//  frame_done    out  1       one-cycle strobe with the last data bit of a frame
// BEHAVIOUR
//  Reset: all outputs 0; accumulator, sample counter, shift reg, bit counter cleared; state HUNT.
//  S1: if sample_valid, prod <= sample_in*carrier (2*DATA_W signed, full precision); p_valid <= sample_valid.
//  S2: on p_valid, acc += sign-extended prod and sample_cnt++.
//    On the SAMPLES_PER_BIT-th product: dec <= (acc+prod >= 0); dec_valid pulses; acc <= 0; sample_cnt <= 0.
//  Invalid cycles advance nothing; gaps of any length in sample_valid are allowed.
//  Symbol timing: the bit grid is fixed by the first valid sample after reset/resync; no timing recovery.
//  S3 output regs: bit_valid/frame_done/locked change exactly 3 cycles after the sample_valid cycle carrying a bit's last sample.
//  FSM HUNT:
//    each dec shifts into sh[7:0] (newest at LSB).
//    sh==PREAMBLE -> LOCKED, inverted<=0.
//    sh==~PREAMBLE -> LOCKED, inverted<=1.
//    Preamble bits are never output.
//  FSM LOCKED:
//    each dec -> bit_out <= dec ^ inverted, bit_valid pulse, bit_cnt++.
//    On bit FRAME_BITS: frame_done pulses with that bit_valid.
//    Next cycle: locked<=0, sh<=0, bit_cnt<=0, state HUNT. inverted holds its value until the next lock.
//  resync (any state): state HUNT, sh/bit_cnt/acc/sample_cnt cleared, locked<=0 next cycle.
//    In-flight S1/S2 data is discarded; a pending bit_valid is suppressed.
//  resync together with the last data bit: resync wins; no bit_valid, no frame_done.
//  No overflow: |prod| <= 2^(2*DATA_W-2), so sum fits ACC_W; no saturation logic.
//  Async reset mid-frame: immediate clear as at reset; no partial bit emitted.
// TESTING
//  1 rst=0 with random inputs -> all outputs 0; after release with no sample_valid -> outputs stay 0.
//  2 carrier=+16384, sample=+8000 for bit 1 / -8000 for bit 0, 16 samples/bit.
//    Send 0xA5 then 64 data bits -> 64 bit_valid equal to data, inverted=0.
//    locked rises 3 cycles after the last preamble sample; frame_done on bit 64; locked=0 one cycle later.
//  3 Same stream as test 2 with every sample negated -> identical bit_out sequence, inverted=1.
//  4 Test 2 with sample_valid only every 3rd cycle -> identical bits; each bit_valid 3 cycles after its last valid sample.
//  5 Assert rst=0 at data bit 20 -> locked=0 at once.
//    Release and resend the frame -> full correct 64-bit frame.
//    Repeat using resync instead of rst -> same result.
//  6 sample=carrier=-32768 for all 16 samples -> sum 2^34, no wrap, decided bit 1.
//    sample=-32768, carrier=+32767 -> decided bit 0.

Source files
------------

// File: rtl/bpsk_rx.sv
// Coherent BPSK demodulator: multiply, integrate-and-dump, preamble hunt with phase-ambiguity fix.
// Three-stage pipeline: outputs follow the sample carrying a bit's last sample by 3 cycles; no backpressure.
module bpsk_rx #(
   parameter int         DATA_W          = 16,
   parameter int         SAMPLES_PER_BIT = 16,
   parameter int         ACC_W           = 40,
   parameter logic [7:0] PREAMBLE        = 8'hA5,
   parameter int         FRAME_BITS      = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [DATA_W-1:0] carrier,
   input  logic              sample_valid,
   input  logic              resync,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              locked,
   output logic              inverted,
   output logic              frame_done
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int CNT_W  = $clog2(SAMPLES_PER_BIT);
   localparam int BCNT_W = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_LOCKED,
      ST_DONE
   } state_t;

   // S1: full-precision product
   logic signed [PROD_W-1:0] smp_ext, car_ext;
   logic signed [PROD_W-1:0] prod_d, prod_q;
   logic                     p_vld_d, p_vld_q;

   // S2: integrate and dump
   logic signed [ACC_W-1:0]  prod_ext, acc_sum;
   logic signed [ACC_W-1:0]  acc_d, acc_q;
   logic [CNT_W-1:0]         cnt_d, cnt_q;
   logic                     dec_d, dec_q;
   logic                     dec_vld_d, dec_vld_q;

   // S3: frame FSM and output registers
   state_t                   state_d, state_q;
   logic [7:0]               sh_d, sh_q, sh_next;
   logic [BCNT_W-1:0]        bcnt_d, bcnt_q;
   logic                     bit_out_d, bit_out_q;
   logic                     bit_vld_d, bit_vld_q;
   logic                     locked_d, locked_q;
   logic                     inv_d, inv_q;
   logic                     fd_d, fd_q;

   assign smp_ext = {{DATA_W{sample_in[DATA_W-1]}}, sample_in};
   assign car_ext = {{DATA_W{carrier[DATA_W-1]}}, carrier};

   always_comb begin
      prod_d  = prod_q;
      p_vld_d = sample_valid & ~resync;
      if (sample_valid) begin
         prod_d = smp_ext * car_ext;
      end
   end

   assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
   assign acc_sum  = acc_q + prod_ext;

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      dec_d     = dec_q;
      dec_vld_d = 1'b0;
      if (resync) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (p_vld_q) begin
         if (cnt_q == CNT_W'(SAMPLES_PER_BIT - 1)) begin
            // A zero sum decides 1 so an all-zero input yields a defined bit.
            dec_d     = ~acc_sum[ACC_W-1];
            dec_vld_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign sh_next = {sh_q[6:0], dec_q};

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      bcnt_d    = bcnt_q;
      bit_out_d = bit_out_q;
      bit_vld_d = 1'b0;
      locked_d  = locked_q;
      inv_d     = inv_q;
      fd_d      = 1'b0;
      if (resync) begin
         state_d  = ST_HUNT;
         sh_d     = '0;
         bcnt_d   = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            ST_HUNT: begin
               if (dec_vld_q) begin
                  sh_d = sh_next;
                  if (sh_next == PREAMBLE) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                     inv_d    = 1'b0;
                     bcnt_d   = '0;
                  end else if (sh_next == ~PREAMBLE) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                     inv_d    = 1'b1;
                     bcnt_d   = '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (dec_vld_q) begin
                  bit_out_d = dec_q ^ inv_q;
                  bit_vld_d = 1'b1;
                  bcnt_d    = bcnt_q + BCNT_W'(1);
                  if (bcnt_q == BCNT_W'(FRAME_BITS - 1)) begin
                     fd_d    = 1'b1;
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // locked stays up for the frame_done cycle, then drops here.
               state_d  = ST_HUNT;
               locked_d = 1'b0;
               sh_d     = '0;
               bcnt_d   = '0;
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q    <= '0;
         p_vld_q   <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         dec_q     <= 1'b0;
         dec_vld_q <= 1'b0;
         state_q   <= ST_HUNT;
         sh_q      <= '0;
         bcnt_q    <= '0;
         bit_out_q <= 1'b0;
         bit_vld_q <= 1'b0;
         locked_q  <= 1'b0;
         inv_q     <= 1'b0;
         fd_q      <= 1'b0;
      end else begin
         prod_q    <= prod_d;
         p_vld_q   <= p_vld_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         dec_q     <= dec_d;
         dec_vld_q <= dec_vld_d;
         state_q   <= state_d;
         sh_q      <= sh_d;
         bcnt_q    <= bcnt_d;
         bit_out_q <= bit_out_d;
         bit_vld_q <= bit_vld_d;
         locked_q  <= locked_d;
         inv_q     <= inv_d;
         fd_q      <= fd_d;
      end
   end

   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_vld_q;
   assign locked     = locked_q;
   assign inverted   = inv_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_bpsk_rx.sv
// Bench for bpsk_rx: an event-scheduling model predicts per-cycle outputs from decided bit sums.
module tb_bpsk_rx;

   localparam int MAXC = 16384;
   localparam logic [63:0] DATA = 64'hDEAD_BEEF_0123_C3A5;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sample_in, carrier;
   logic        sample_valid, resync;
   logic        bit_out, bit_valid, locked, inverted, frame_done;

   always #5 clk = ~clk;

   bpsk_rx dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .carrier      (carrier),
      .sample_valid (sample_valid),
      .resync       (resync),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .locked       (locked),
      .inverted     (inverted),
      .frame_done   (frame_done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Expected output events, indexed by the cycle at which they must be visible.
   bit ev_bv[MAXC], ev_bit[MAXC], ev_fd[MAXC];
   bit ev_lock_set[MAXC], ev_lock_clr[MAXC], ev_inv_en[MAXC], ev_inv_val[MAXC];

   longint      m_sum;
   int          m_cnt, m_bits;
   logic [7:0]  m_sh;
   bit          m_hunt, m_dinv;
   bit          m_locked = 1'b0, m_inv = 1'b0;

   logic [63:0] got;
   int          got_n, fd_n;
   logic [63:0] data_v = DATA;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear(input int from);
      for (int i = from; i < MAXC; i++) begin
         ev_bv[i] = 0; ev_bit[i] = 0; ev_fd[i] = 0;
         ev_lock_set[i] = 0; ev_lock_clr[i] = 0; ev_inv_en[i] = 0; ev_inv_val[i] = 0;
      end
      m_sum = 0; m_cnt = 0; m_sh = 8'h00; m_hunt = 1; m_bits = 0;
   endtask

   task automatic model_bit(input bit d, input int e);
      if (m_hunt) begin
         m_sh = {m_sh[6:0], d};
         if (m_sh == 8'hA5 || m_sh == 8'h5A) begin
            m_hunt = 0;
            m_bits = 0;
            m_dinv = (m_sh == 8'h5A);
            ev_lock_set[e] = 1;
            ev_inv_en[e]   = 1;
            ev_inv_val[e]  = m_dinv;
         end
      end else begin
         ev_bv[e]  = 1;
         ev_bit[e] = d ^ m_dinv;
         m_bits++;
         if (m_bits == 64) begin
            ev_fd[e] = 1;
            ev_lock_clr[e+1] = 1;
            m_hunt = 1;
            m_sh = 8'h00;
         end
      end
   endtask

   task automatic drive(input bit v, input int s, input int c, input bit rs);
      @(posedge clk);
      #1;
      if (cyc + 4 >= MAXC) begin
         $display("FAIL cycle_budget: actual %0d required below %0d", cyc, MAXC - 4);
         $fatal(1);
      end
      sample_valid = v;
      sample_in    = s[15:0];
      carrier      = c[15:0];
      resync       = rs;
      if (rst) begin
         if (rs) begin
            model_clear(cyc + 1);
            ev_lock_clr[cyc+1] = 1;
         end else if (v) begin
            m_sum += longint'(s) * longint'(c);
            m_cnt++;
            if (m_cnt == 16) begin
               model_bit(m_sum >= 0, cyc + 3);
               m_sum = 0;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 16384, 0);
   endtask

   task automatic send_bit(input bit b, input bit neg, input int gap);
      int a;
      a = b ? 8000 : -8000;
      if (neg) a = -a;
      for (int i = 0; i < 16; i++) begin
         drive(1, a, 16384, 0);
         idle(gap);
      end
   endtask

   task automatic send_preamble(input bit neg, input int gap);
      logic [7:0] p;
      p = 8'hA5;
      for (int i = 7; i >= 0; i--) send_bit(p[i], neg, gap);
   endtask

   task automatic send_data(input bit neg, input int gap, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(data_v[63-i], neg, gap);
   endtask

   task automatic clear_got();
      got = '0; got_n = 0; fd_n = 0;
   endtask

   task automatic release_rst(input int n);
      repeat (n) drive(1'($urandom), int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768, 1'($urandom));
      @(posedge clk);
      #1;
      rst = 1; sample_valid = 0; resync = 0;
   endtask

   always @(negedge clk) begin : cmp
      bit e_bv, e_bit, e_fd;
      if (cyc < MAXC) begin
         if (ev_lock_set[cyc]) m_locked = 1;
         if (ev_lock_clr[cyc]) m_locked = 0;
         if (ev_inv_en[cyc])   m_inv = ev_inv_val[cyc];
         if (!rst) begin
            m_locked = 0;
            m_inv    = 0;
         end
         e_bv  = rst & ev_bv[cyc];
         e_bit = ev_bit[cyc];
         e_fd  = rst & ev_fd[cyc];
         chk("bit_valid", bit_valid, e_bv);
         chk("frame_done", frame_done, e_fd);
         chk("locked", locked, m_locked);
         chk("inverted", inverted, m_inv);
         if (e_bv) chk("bit_out", bit_out, e_bit);
         if (!rst) chk("bit_out_reset", bit_out, 0);
         if (rst && bit_valid === 1'b1) begin
            got = {got[62:0], bit_out};
            got_n++;
         end
         if (rst && frame_done === 1'b1) fd_n++;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   initial begin
      rst = 0; sample_in = 0; carrier = 0; sample_valid = 0; resync = 0;
      m_dinv = 0;
      model_clear(0);
      clear_got();

      // reset with random inputs, then quiet after release
      release_rst(8);
      idle(10);
      chk("t1_locked", locked, 0);
      chk("t1_bit_valid", bit_valid, 0);

      // normal frame, lock timing pinned by hand
      clear_got();
      send_preamble(0, 0);
      for (int k = 1; k <= 3; k++) begin
         idle(1);
         @(negedge clk);
         if (k == 2) chk("t2_lock_early", locked, 0);
         if (k == 3) chk("t2_lock_rise", locked, 1);
      end
      send_data(0, 0, 64);
      idle(8);
      chk("t2_data", got, DATA);
      chk("t2_count", got_n, 64);
      chk("t2_frame_done", fd_n, 1);
      chk("t2_inverted", inverted, 0);
      chk("t2_unlocked", locked, 0);

      // negated stream
      clear_got();
      send_preamble(1, 0);
      send_data(1, 0, 64);
      idle(8);
      chk("t3_data", got, DATA);
      chk("t3_inverted", inverted, 1);

      // valid every third cycle
      clear_got();
      send_preamble(0, 2);
      send_data(0, 2, 64);
      idle(8);
      chk("t4_data", got, DATA);
      chk("t4_count", got_n, 64);
      chk("t4_inverted", inverted, 0);

      // async reset mid-frame, then full frame
      send_preamble(0, 0);
      send_data(0, 0, 20);
      @(posedge clk);
      #1;
      chk("t5_locked_before", locked, 1);
      rst = 0;
      model_clear(cyc);
      #1;
      chk("t5_locked_async", locked, 0);
      release_rst(4);
      clear_got();
      send_preamble(0, 0);
      send_data(0, 0, 64);
      idle(8);
      chk("t5_rst_data", got, DATA);
      chk("t5_rst_count", got_n, 64);

      // resync mid-frame, then full frame
      send_preamble(0, 0);
      send_data(0, 0, 20);
      drive(0, 0, 16384, 1);
      idle(2);
      @(negedge clk);
      chk("t5_resync_unlock", locked, 0);
      idle(4);
      clear_got();
      send_preamble(0, 0);
      send_data(0, 0, 64);
      idle(8);
      chk("t5_resync_data", got, DATA);
      chk("t5_resync_count", got_n, 64);

      // full-scale products: sum 2^34 decides 1, negative extreme decides 0
      clear_got();
      send_preamble(0, 0);
      repeat (16) drive(1, -32768, -32768, 0);
      repeat (16) drive(1, -32768, 32767, 0);
      idle(5);
      chk("t6_count", got_n, 2);
      chk("t6_bits", got[1:0], 2'b10);
      drive(0, 0, 16384, 1);
      idle(4);
      chk("t6_unlocked", locked, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
